// File: rtl/microgreen_feature_conditioner.sv
// Sensor front end for the microgreen classifier: averages four 4-bit features over
// 2^LOG2_N strobed samples (round-half-up) and holds the result behind a valid/ready handshake.
module microgreen_feature_conditioner #(
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [3:0]        height_raw,
    input  logic [3:0]        color_raw,
    input  logic [3:0]        density_raw,
    input  logic [3:0]        texture_raw,
    input  logic              feat_ready,
    output logic              feat_valid,
    output logic [3:0]        feat_height,
    output logic [3:0]        feat_color,
    output logic [3:0]        feat_density,
    output logic [3:0]        feat_texture,
    output logic [LOG2_N-1:0] sample_count,
    output logic              overrun
);
    localparam int ACC_W = 4 + LOG2_N;
    localparam int SW    = ACC_W + 1;
    localparam int N     = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] LAST = LOG2_N'(N - 1);

    logic [LOG2_N-1:0] count_q, count_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              complete, xfer, load;
    logic [15:0]       raw_vec;
    logic [15:0]       feat_vec;

    assign raw_vec  = {texture_raw, density_raw, color_raw, height_raw};
    assign complete = sample_valid && (count_q == LAST);
    assign xfer     = valid_q && feat_ready;
    // A finished window only replaces the held set if the slot is empty or being drained now.
    assign load     = complete && (!valid_q || xfer);

    always_comb begin
        count_d   = count_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (clear) begin
            count_d   = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (sample_valid) begin
                count_d = complete ? '0 : count_q + 1'b1;
            end
            if (load) begin
                valid_d = 1'b1;
            end else if (complete) begin
                overrun_d = 1'b1;
            end else if (xfer) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (ena) begin
            count_q   <= count_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_feat
            logic [3:0]       raw;
            logic [ACC_W-1:0] acc_q, acc_d;
            logic [3:0]       feat_q, feat_d;
            logic [SW-1:0]    sum_w, shift_w;
            logic [3:0]       avg;

            assign raw     = raw_vec[gi*4 +: 4];
            // The Nth sample joins the sum directly so the window closes on its own strobe.
            assign sum_w   = {1'b0, acc_q} + SW'(raw) + SW'(N / 2);
            assign shift_w = sum_w >> LOG2_N;
            assign avg     = (shift_w > SW'(15)) ? 4'hF : shift_w[3:0];

            always_comb begin
                acc_d  = acc_q;
                feat_d = feat_q;
                if (clear) begin
                    acc_d  = '0;
                    feat_d = '0;
                end else begin
                    if (sample_valid) begin
                        acc_d = complete ? '0 : acc_q + ACC_W'(raw);
                    end
                    if (load) begin
                        feat_d = avg;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q  <= '0;
                    feat_q <= '0;
                end else if (ena) begin
                    acc_q  <= acc_d;
                    feat_q <= feat_d;
                end
            end

            assign feat_vec[gi*4 +: 4] = feat_q;
        end
    endgenerate

    assign feat_valid   = valid_q;
    assign sample_count = count_q;
    assign overrun      = overrun_q;
    assign feat_height  = feat_vec[3:0];
    assign feat_color   = feat_vec[7:4];
    assign feat_density = feat_vec[11:8];
    assign feat_texture = feat_vec[15:12];
endmodule

// File: tb/tb_microgreen_feature_conditioner.sv
// Self-checking bench: a behavioural averaging model pushes expected feature sets to a
// scoreboard as samples are driven; each scenario pops and compares when the DUT loads one.
module tb_microgreen_feature_conditioner;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic              clk = 1'b0;
    logic              rst_n, ena, clear, sample_valid, feat_ready;
    logic [3:0]        height_raw, color_raw, density_raw, texture_raw;
    logic              feat_valid, overrun;
    logic [3:0]        feat_height, feat_color, feat_density, feat_texture;
    logic [LOG2_N-1:0] sample_count;
    logic [15:0]       feat_all;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          m_sum[4];
    int          m_cnt;
    bit          m_valid, m_ovr;
    logic [15:0] exp_w, held;

    always #5 clk = ~clk;

    microgreen_feature_conditioner #(.LOG2_N(LOG2_N)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .sample_valid(sample_valid),
        .height_raw(height_raw), .color_raw(color_raw),
        .density_raw(density_raw), .texture_raw(texture_raw),
        .feat_ready(feat_ready), .feat_valid(feat_valid),
        .feat_height(feat_height), .feat_color(feat_color),
        .feat_density(feat_density), .feat_texture(feat_texture),
        .sample_count(sample_count), .overrun(overrun)
    );

    assign feat_all = {feat_texture, feat_density, feat_color, feat_height};

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_sum[k] = 0;
        m_cnt   = 0;
        m_valid = 0;
        m_ovr   = 0;
        exp_q.delete();
    endtask

    // Drive one cycle ({texture,density,color,height}) and advance the reference model.
    task automatic step(input bit sv, input logic [15:0] raws, input bit rdy);
        bit          done, xf;
        logic [15:0] avg;
        int          a;
        avg = '0;
        sample_valid = sv;
        {texture_raw, density_raw, color_raw, height_raw} = raws;
        feat_ready = rdy;
        done = sv && (m_cnt == N - 1);
        xf   = m_valid && rdy;
        if (sv) begin
            for (int k = 0; k < 4; k++) m_sum[k] += int'(raws[k*4 +: 4]);
            if (done) begin
                for (int k = 0; k < 4; k++) begin
                    a = (m_sum[k] + N / 2) / N;
                    avg[k*4 +: 4] = (a > 15) ? 4'd15 : 4'(a);
                    m_sum[k] = 0;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (done) begin
            if (!m_valid || xf) begin
                exp_q.push_back(avg);
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (xf) begin
            m_valid = 0;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        feat_ready   = 1'b0;
    endtask

    task automatic window(input logic [3:0] v, input bit last_rdy);
        for (int i = 0; i < N - 1; i++) step(1'b1, {4{v}}, 1'b0);
        step(1'b1, {4{v}}, last_rdy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; clear = 1'b0; sample_valid = 1'b0; feat_ready = 1'b0;
        {texture_raw, density_raw, color_raw, height_raw} = '0;
        #3;
        checks++; if (feat_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", feat_valid); end
        checks++; if (feat_all !== 16'h0) begin errors++; $display("FAIL reset_feat: got %h want 0000", feat_all); end
        checks++; if (sample_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", sample_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++; if (feat_valid !== 1'b0 || sample_count !== '0) begin errors++; $display("FAIL post_reset_idle: got valid=%b count=%0d want 0/0", feat_valid, sample_count); end
        $display("test_reset done");
    endtask

    task automatic test_average();
        step(1'b1, {4'd8, 4'd8, 4'd8, 4'd3}, 1'b0);
        step(1'b1, {4'd8, 4'd8, 4'd8, 4'd4}, 1'b0);
        step(1'b1, {4'd8, 4'd8, 4'd8, 4'd4}, 1'b0);
        checks++; if (sample_count !== 2'd3 || feat_valid !== 1'b0) begin errors++; $display("FAIL avg_partial: got count=%0d valid=%b want 3/0", sample_count, feat_valid); end
        step(1'b1, {4'd8, 4'd8, 4'd8, 4'd5}, 1'b0);
        checks++; if (feat_valid !== 1'b1 || sample_count !== 2'd0) begin errors++; $display("FAIL avg_latency: got valid=%b count=%0d want 1/0", feat_valid, sample_count); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL avg_set: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL avg_set: got %h want %h", feat_all, exp_w); end end
        checks++; if (feat_all !== 16'h8884) begin errors++; $display("FAIL avg_literal: got %h want 8884", feat_all); end
        step(1'b0, '0, 1'b1);
        checks++; if (feat_valid !== 1'b0 || feat_all !== 16'h8884) begin errors++; $display("FAIL avg_accept: got valid=%b feat=%h want 0/8884", feat_valid, feat_all); end
        $display("test_average done: feat=%h", feat_all);
    endtask

    task automatic test_rounding();
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL round_set: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL round_set: got %h want %h", feat_all, exp_w); end end
        checks++; if (feat_height !== 4'd1) begin errors++; $display("FAIL round_height: got %0d want 1", feat_height); end
        step(1'b0, '0, 1'b1);
        window(4'd15, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sat_set: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL sat_set: got %h want %h", feat_all, exp_w); end end
        checks++; if (feat_height !== 4'd15) begin errors++; $display("FAIL sat_height: got %0d want 15", feat_height); end
        step(1'b0, '0, 1'b1);
        $display("test_rounding done");
    endtask

    task automatic test_handshake_hold();
        window(4'd6, 1'b0);
        held = 16'h6666;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL hold_set: no expected entry, got %h", feat_all); end
        else begin held = exp_q.pop_front(); if (feat_all !== held) begin errors++; $display("FAIL hold_set: got %h want %h", feat_all, held); end end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0);
            checks++; if (feat_valid !== 1'b1 || feat_all !== held) begin errors++; $display("FAIL hold_cycle%0d: got valid=%b feat=%h want 1/%h", i, feat_valid, feat_all, held); end
        end
        step(1'b0, '0, 1'b1);
        checks++; if (feat_valid !== 1'b0 || feat_all !== held) begin errors++; $display("FAIL hold_release: got valid=%b feat=%h want 0/%h", feat_valid, feat_all, held); end
        $display("test_handshake_hold done");
    endtask

    task automatic test_overrun();
        window(4'd5, 1'b0);
        held = 16'h5555;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ovr_first: no expected entry, got %h", feat_all); end
        else begin held = exp_q.pop_front(); if (feat_all !== held) begin errors++; $display("FAIL ovr_first: got %h want %h", feat_all, held); end end
        window(4'd9, 1'b0);
        checks++; if (feat_all !== held || feat_valid !== 1'b1) begin errors++; $display("FAIL ovr_kept: got valid=%b feat=%h want 1/%h", feat_valid, feat_all, held); end
        checks++; if (overrun !== m_ovr || exp_q.size() != 0) begin errors++; $display("FAIL ovr_flag: got %b want %b (queued=%0d)", overrun, m_ovr, exp_q.size()); end
        clear = 1'b1; sample_valid = 1'b1; feat_ready = 1'b1;
        {texture_raw, density_raw, color_raw, height_raw} = 16'h3333;
        @(posedge clk); #1;
        clear = 1'b0; sample_valid = 1'b0; feat_ready = 1'b0;
        model_reset();
        checks++; if (feat_valid !== 1'b0 || overrun !== 1'b0 || sample_count !== '0 || feat_all !== 16'h0) begin errors++; $display("FAIL clear: got valid=%b ovr=%b count=%0d feat=%h want all 0", feat_valid, overrun, sample_count, feat_all); end
        $display("test_overrun done");
    endtask

    task automatic test_back_to_back();
        window(4'd2, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_first: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL b2b_first: got %h want %h", feat_all, exp_w); end end
        window(4'd7, 1'b1);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_second: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL b2b_second: got %h want %h", feat_all, exp_w); end end
        checks++; if (feat_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_flags: got valid=%b ovr=%b want 1/0", feat_valid, overrun); end
        step(1'b0, '0, 1'b1);
        checks++; if (feat_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b want 0", feat_valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_ena_freeze();
        window(4'd10, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ena_setup: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL ena_setup: got %h want %h", feat_all, exp_w); end end
        step(1'b1, 16'h4444, 1'b0);
        step(1'b1, 16'h4444, 1'b0);
        ena = 1'b0; sample_valid = 1'b1; feat_ready = 1'b1;
        {texture_raw, density_raw, color_raw, height_raw} = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (sample_count !== 2'd2 || feat_valid !== 1'b1 || feat_all !== 16'hAAAA) begin errors++; $display("FAIL ena_hold%0d: got count=%0d valid=%b feat=%h want 2/1/aaaa", i, sample_count, feat_valid, feat_all); end
        end
        ena = 1'b1; sample_valid = 1'b0; feat_ready = 1'b0;
        step(1'b0, '0, 1'b1);
        step(1'b1, 16'h4444, 1'b0);
        step(1'b1, 16'h4444, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ena_resume: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL ena_resume: got %h want %h", feat_all, exp_w); end end
        step(1'b0, '0, 1'b1);
        $display("test_ena_freeze done");
    endtask

    task automatic test_async_reset();
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (feat_valid !== 1'b0 || feat_all !== 16'h0 || sample_count !== '0 || overrun !== 1'b0) begin errors++; $display("FAIL async_reset: got valid=%b feat=%h count=%0d ovr=%b want all 0", feat_valid, feat_all, sample_count, overrun); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        window(4'd2, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL post_reset_avg: no expected entry, got %h", feat_all); end
        else begin exp_w = exp_q.pop_front(); if (feat_all !== exp_w) begin errors++; $display("FAIL post_reset_avg: got %h want %h", feat_all, exp_w); end end
        $display("test_async_reset done: feat=%h", feat_all);
    endtask

    initial begin
        test_reset();
        test_average();
        test_rounding();
        test_handshake_hold();
        test_overrun();
        test_back_to_back();
        test_ena_freeze();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
